// File: rtl/fetch.sv
// Instruction fetch stage: walks the PC against a 1-cycle-latency instruction memory,
// buffers responses in a 2-entry queue and hands the head to the select stage.
module fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ins,
    output logic [15:0] ins_pc,
    output logic        halted
);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    entry_t      q [2];
    logic        head;
    logic [1:0]  count;
    logic [15:0] pc;
    logic        inflight;
    logic [15:0] inflight_pc;
    logic        drop;
    logic        stop;

    entry_t      head_e;
    logic        valid_out;
    logic        pop;
    logic        fill;
    logic        wr_idx;
    logic [1:0]  occupancy;

    always_comb begin
        head_e    = q[head];
        valid_out = (count != 2'd0) && !branch_en && !halted;
        ins       = valid_out ? head_e.instr : 16'h0000;
        ins_pc    = valid_out ? head_e.pc : 16'h0000;
        pop       = valid_out && !stall;
        // A response is useless once a redirect flushed it or a HALT was already queued.
        fill      = inflight && !drop && !stop && !branch_en;
        wr_idx    = head ^ count[0];
        // Queue entries plus the outstanding request never exceed two, so 2 bits suffice.
        occupancy = count + {1'b0, inflight} - {1'b0, pop};
        imem_en   = !rst && !stop && !halted && !branch_en && (occupancy < 2'd2);
        imem_addr = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            head        <= 1'b0;
            count       <= 2'd0;
            inflight    <= 1'b0;
            inflight_pc <= 16'h0000;
            drop        <= 1'b0;
            stop        <= 1'b0;
            halted      <= 1'b0;
        end else if (branch_en) begin
            pc       <= branch_target;
            head     <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
            drop     <= inflight;
            stop     <= 1'b0;
        end else begin
            // NOTE: all state updates here are non-blocking so every comb signal above
            // (pop, fill, imem_en) is evaluated against the same pre-edge state.
            drop     <= 1'b0;
            inflight <= imem_en;
            if (imem_en) begin
                pc          <= pc + 16'd1;
                inflight_pc <= pc;
            end
            case ({fill, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (pop) begin
                head <= ~head;
                if (head_e.instr[15:12] == HALT_OP)
                    halted <= 1'b1;
            end
            if (fill && (imem_data[15:12] == HALT_OP))
                stop <= 1'b1;
        end
    end

    // NOTE: queue payload is not reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (fill)
            q[wr_idx] <= '{pc: inflight_pc, instr: imem_data};
    end

endmodule

// File: tb/tb_fetch.sv
// Directed, table-driven bench for the fetch stage with a behavioural 1-cycle instruction memory.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_en;
    logic [15:0] branch_target;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ins;
    logic [15:0] ins_pc;
    logic        halted;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] imem [0:65535];
    logic        mon_on = 1'b0;
    logic [15:0] max_addr = 16'h0000;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        en;
        logic [15:0] addr;
        logic [15:0] ins;
        logic [15:0] ipc;
        logic        halted;
    } vec_t;

    vec_t vecs[$];

    fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .ins(ins), .ins_pc(ins_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en)
            imem_data <= imem[imem_addr];
    end

    always @(negedge clk) begin
        if (mon_on && imem_en && (imem_addr > max_addr))
            max_addr = imem_addr;
        if (!rst && dut.fill && (dut.count == 2'd2)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL queue_overflow: fill into full queue at time %0t", $time);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic s, input logic b, input logic [15:0] t,
                                input logic e, input logic [15:0] a, input logic [15:0] i,
                                input logic [15:0] p, input logic h);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.en = e;
        v.addr = a; v.ins = i; v.ipc = p; v.halted = h;
        vecs.push_back(v);
    endfunction

    // Called at #1 after a posedge; returns at #1 after the next posedge.
    task automatic run_vec(input vec_t v, input int idx);
        stall         = v.stall;
        branch_en     = v.br;
        branch_target = v.tgt;
        @(negedge clk);
        check($sformatf("v%0d.imem_en", idx), {15'd0, imem_en}, {15'd0, v.en});
        check($sformatf("v%0d.imem_addr", idx), imem_addr, v.addr);
        check($sformatf("v%0d.ins", idx), ins, v.ins);
        check($sformatf("v%0d.ins_pc", idx), ins_pc, v.ipc);
        check($sformatf("v%0d.halted", idx), {15'd0, halted}, {15'd0, v.halted});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = 16'h0000;
        @(posedge clk);
        #1;
        check("rst.imem_en", {15'd0, imem_en}, 16'h0000);
        check("rst.ins", ins, 16'h0000);
        check("rst.ins_pc", ins_pc, 16'h0000);
        check("rst.halted", {15'd0, halted}, 16'h0000);
        rst = 1'b0;
    endtask

    task automatic run_all(input int base);
        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], base + i);
        vecs.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++)
            imem[i] = {4'h1, i[11:0]};
        rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = 16'h0000;
        @(posedge clk);
        #1;
        do_reset();

        // Start-up stream, 5-cycle stall on 1003, redirects (with drop, back-to-back,
        // redirect while drop pending) and PC wrap.  stall br tgt | en addr ins ins_pc halted
        add(0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0); // c0
        add(0, 0, 16'h0000, 1, 16'h0001, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0002, 16'h1000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0003, 16'h1001, 16'h0001, 0);
        add(0, 0, 16'h0000, 1, 16'h0004, 16'h1002, 16'h0002, 0);
        add(1, 0, 16'h0000, 0, 16'h0005, 16'h1003, 16'h0003, 0); // c5 stall
        for (int i = 0; i < 4; i++)
            add(1, 0, 16'h0000, 0, 16'h0005, 16'h1003, 16'h0003, 0);
        add(0, 0, 16'h0000, 1, 16'h0005, 16'h1003, 16'h0003, 0); // c10 release
        add(0, 0, 16'h0000, 1, 16'h0006, 16'h1004, 16'h0004, 0);
        add(0, 0, 16'h0000, 1, 16'h0007, 16'h1005, 16'h0005, 0);
        add(0, 0, 16'h0000, 1, 16'h0008, 16'h1006, 16'h0006, 0);
        add(0, 1, 16'h0040, 0, 16'h0009, 16'h0000, 16'h0000, 0); // c14 branch, inflight=1
        add(0, 0, 16'h0000, 1, 16'h0040, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0041, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0042, 16'h1040, 16'h0040, 0);
        add(0, 0, 16'h0000, 1, 16'h0043, 16'h1041, 16'h0041, 0);
        add(1, 0, 16'h0000, 0, 16'h0044, 16'h1042, 16'h0042, 0); // c19 fill queue to 2
        add(0, 1, 16'h0010, 0, 16'h0044, 16'h0000, 16'h0000, 0); // c20 branch, count=2
        add(0, 1, 16'h0020, 0, 16'h0010, 16'h0000, 16'h0000, 0); // c21 back-to-back
        add(0, 0, 16'h0000, 1, 16'h0020, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0021, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0022, 16'h1020, 16'h0020, 0);
        add(0, 0, 16'h0000, 1, 16'h0023, 16'h1021, 16'h0021, 0);
        add(0, 1, 16'h0030, 0, 16'h0024, 16'h0000, 16'h0000, 0); // c26 branch, sets drop
        add(0, 1, 16'h0050, 0, 16'h0030, 16'h0000, 16'h0000, 0); // c27 branch while drop
        add(0, 0, 16'h0000, 1, 16'h0050, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0051, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0052, 16'h1050, 16'h0050, 0);
        add(0, 0, 16'h0000, 1, 16'h0053, 16'h1051, 16'h0051, 0);
        add(0, 1, 16'hFFFF, 0, 16'h0054, 16'h0000, 16'h0000, 0); // c32 branch to top
        add(0, 0, 16'h0000, 1, 16'hFFFF, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0001, 16'h1FFF, 16'hFFFF, 0);
        add(0, 0, 16'h0000, 1, 16'h0002, 16'h1000, 16'h0000, 0);
        run_all(0);

        // HALT at address 5, with a reset issued mid-stream first.
        imem[5] = 16'hF000;
        do_reset();
        max_addr = 16'h0000;
        mon_on   = 1'b1;
        add(0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0001, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0002, 16'h1000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0003, 16'h1001, 16'h0001, 0);
        add(0, 0, 16'h0000, 1, 16'h0004, 16'h1002, 16'h0002, 0);
        add(0, 0, 16'h0000, 1, 16'h0005, 16'h1003, 16'h0003, 0);
        add(0, 0, 16'h0000, 1, 16'h0006, 16'h1004, 16'h0004, 0);
        add(0, 0, 16'h0000, 0, 16'h0007, 16'hF000, 16'h0005, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 16'h0000, 0, 16'h0007, 16'h0000, 16'h0000, 1);
        run_all(100);
        mon_on = 1'b0;
        check("halt.max_addr", max_addr, 16'h0006);

        // Reset leaves the halted state and restarts at RESET_PC.
        imem[5] = 16'h1005;
        do_reset();
        add(0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0001, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0002, 16'h1000, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 16'h0003, 16'h1001, 16'h0001, 0);
        run_all(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
